// File: rtl/alu_dispatch.sv
// Initiator side of the ALU operand/result interface: accepts one request, issues it to the
// ALU as a single en pulse, captures the result after LATENCY cycles and returns it with its tag.
module alu_dispatch #(
    parameter int DATA_W  = 64,
    parameter int OP_W    = 8,
    parameter int TAG_W   = 4,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_opcode,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [OP_W-1:0]  OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(8);
    localparam logic [1:0]       ERR_OK   = 2'b00;
    localparam logic [1:0]       ERR_ILL  = 2'b01;
    localparam logic [1:0]       ERR_DIV0 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              alu_en_q, alu_en_d;
    logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_en_d     = alu_en_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_tag_d = req_tag;
                    if (req_opcode > OP_LAST) begin
                        rsp_err_d   = ERR_ILL;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (req_opcode == OP_DIV && req_b == '0) begin
                        rsp_err_d   = ERR_DIV0;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_opcode_d = req_opcode;
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        alu_en_d     = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_en_d = 1'b0;
                cnt_d    = CNT_W'(LATENCY);
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // alu_result is only looked at on this edge; it may be undefined elsewhere.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d  = alu_result;
                    rsp_err_d   = ERR_OK;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a small control/data flop, so all take a reset value.
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_en_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_en_q     <= alu_en_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign alu_en       = alu_en_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_operand1 = alu_a_q;
    assign alu_operand2 = alu_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a LATENCY=1 and a LATENCY=3 instance, each with a behavioural ALU,
// driven with directed and random requests checked against a transaction-level reference.
module tb_alu_dispatch;

    logic clk;
    logic rst_n;

    logic        req_valid    [2];
    logic        req_ready    [2];
    logic [7:0]  req_opcode   [2];
    logic [63:0] req_a        [2];
    logic [63:0] req_b        [2];
    logic [3:0]  req_tag      [2];
    logic        alu_en       [2];
    logic [7:0]  alu_opcode   [2];
    logic [63:0] alu_operand1 [2];
    logic [63:0] alu_operand2 [2];
    logic [63:0] alu_result   [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [63:0] rsp_data     [2];
    logic [3:0]  rsp_tag      [2];
    logic [1:0]  rsp_err      [2];
    logic        busy         [2];

    int nchecks = 0;
    int nerrors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_dispatch #(.DATA_W(64), .OP_W(8), .TAG_W(4), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_opcode(req_opcode[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
        .alu_en(alu_en[0]), .alu_opcode(alu_opcode[0]),
        .alu_operand1(alu_operand1[0]), .alu_operand2(alu_operand2[0]),
        .alu_result(alu_result[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_tag(rsp_tag[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    alu_dispatch #(.DATA_W(64), .OP_W(8), .TAG_W(4), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_opcode(req_opcode[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
        .alu_en(alu_en[1]), .alu_opcode(alu_opcode[1]),
        .alu_operand1(alu_operand1[1]), .alu_operand2(alu_operand2[1]),
        .alu_result(alu_result[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_tag(rsp_tag[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Arithmetic meaning of each opcode; shifts use the low 6 bits of operand2.
    function automatic logic [63:0] alu_math(input logic [7:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a * b;
            8'd3:    return (b == 0) ? 64'd0 : a / b;
            8'd4:    return a << b[5:0];
            8'd5:    return a >> b[5:0];
            8'd6:    return a & b;
            8'd7:    return a | b;
            8'd8:    return a ^ b;
            default: return 64'd0;
        endcase
    endfunction

    // Expected response for one request, straight from the dispatch rules.
    task automatic ref_model(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                             output logic [1:0] err, output logic [63:0] data);
        if (op > 8'd8) begin
            err = 2'b01; data = 64'd0;
        end else if (op == 8'd3 && b == 64'd0) begin
            err = 2'b10; data = 64'd0;
        end else begin
            err = 2'b00; data = alu_math(op, a, b);
        end
    endtask

    // Behavioural ALU: registers a result when it samples en, otherwise shows noise so a
    // capture on the wrong edge picks up garbage.
    logic [63:0] alu_res_q [2];
    logic        win_q     [2];
    logic [63:0] noise_q;

    always @(posedge clk) noise_q <= {$urandom, $urandom};

    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                win_q[g]     <= 1'b0;
                alu_res_q[g] <= 64'd0;
            end else if (alu_en[g]) begin
                alu_res_q[g] <= alu_math(alu_opcode[g], alu_operand1[g], alu_operand2[g]);
                win_q[g]     <= 1'b1;
            end else if (rsp_valid[g]) begin
                win_q[g] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) alu_result[g] = win_q[g] ? alu_res_q[g] : noise_q;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance d; hold = cycles the response is back-pressured.
    task automatic do_op(input int d, input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] tag, input int hold,
                         input string name);
        logic [1:0]  e_err;
        logic [63:0] e_data;
        int          e_lat;
        int          cyc;
        int          ens;
        bit          seen;
        ref_model(op, a, b, e_err, e_data);
        e_lat = (e_err != 2'b00) ? 0 : lat_of(d) + 1;

        @(negedge clk);
        check({name, ".req_ready_idle"}, 64'(req_ready[d]), 64'd1);
        req_valid[d]  = 1'b1;
        req_opcode[d] = op;
        req_a[d]      = a;
        req_b[d]      = b;
        req_tag[d]    = tag;
        rsp_ready[d]  = (hold == 0);
        @(posedge clk); #1;
        // Keep a junk request pending: it must be ignored until the response has left.
        req_opcode[d] = 8'($urandom);
        req_a[d]      = {$urandom, $urandom};
        req_b[d]      = {$urandom, $urandom};
        req_tag[d]    = 4'($urandom);

        cyc = 0; ens = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (alu_en[d]) begin
                ens++;
                check({name, ".alu_opcode"}, 64'(alu_opcode[d]), 64'(op));
                check({name, ".alu_operand1"}, alu_operand1[d], a);
                check({name, ".alu_operand2"}, alu_operand2[d], b);
            end
            if (rsp_valid[d]) begin
                seen = 1;
            end else begin
                check({name, ".req_ready_busy"}, 64'(req_ready[d]), 64'd0);
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({name, ".latency"}, 64'(cyc), 64'(e_lat));
        check({name, ".alu_en_pulses"}, 64'(ens), (e_err == 2'b00) ? 64'd1 : 64'd0);
        check({name, ".rsp_data"}, rsp_data[d], e_data);
        check({name, ".rsp_tag"}, 64'(rsp_tag[d]), 64'(tag));
        check({name, ".rsp_err"}, 64'(rsp_err[d]), 64'(e_err));
        check({name, ".req_ready_resp"}, 64'(req_ready[d]), 64'd0);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 64'(rsp_valid[d]), 64'd1);
            check({name, ".hold_data"}, rsp_data[d], e_data);
            check({name, ".hold_tag"}, 64'(rsp_tag[d]), 64'(tag));
            check({name, ".hold_ready"}, 64'(req_ready[d]), 64'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        check({name, ".rsp_gone"}, 64'(rsp_valid[d]), 64'd0);
        check({name, ".back_idle"}, 64'(req_ready[d]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          ncyc_valid;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_opcode[d] = '0; req_a[d] = '0; req_b[d] = '0;
            req_tag[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset.alu_en", 64'(alu_en[0]), 64'd0);
        check("reset.rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("reset.rsp_data", rsp_data[0], 64'd0);
        check("reset.rsp_tag", 64'(rsp_tag[0]), 64'd0);
        check("reset.rsp_err", 64'(rsp_err[0]), 64'd0);
        check("reset.alu_operand1", alu_operand1[0], 64'd0);
        check("reset.busy", 64'(busy[0]), 64'd0);
        check("reset.req_ready", 64'(req_ready[0]), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        do_op(0, 8'd0, 64'd5, 64'd7, 4'd3, 0, "add");
        do_op(0, 8'd3, 64'd100, 64'd0, 4'd1, 0, "div0");
        do_op(0, 8'd3, 64'd100, 64'd7, 4'd2, 0, "div");
        do_op(0, 8'd9, 64'd11, 64'd22, 4'hA, 0, "illegal");
        do_op(0, 8'd1, 64'd3, 64'd5, 4'd6, 5, "sub_hold");
        check("sub_hold.value", 64'hFFFF_FFFF_FFFF_FFFE, alu_math(8'd1, 64'd3, 64'd5));

        // Reset while the op is in ISSUE: alu_en must fall without waiting for a clock.
        @(negedge clk);
        req_valid[0] = 1'b1; req_opcode[0] = 8'd2; req_a[0] = 64'd6; req_b[0] = 64'd7;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("rst_issue.en_before", 64'(alu_en[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_issue.en_async", 64'(alu_en[0]), 64'd0);
        check("rst_issue.busy", 64'(busy[0]), 64'd0);
        check("rst_issue.opcode", 64'(alu_opcode[0]), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset while the op is in WAIT: the op is dropped and no response ever appears.
        @(negedge clk);
        req_valid[0] = 1'b1; req_opcode[0] = 8'd2; req_a[0] = 64'd6; req_b[0] = 64'd7;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_wait.busy_before", 64'(busy[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wait.alu_en", 64'(alu_en[0]), 64'd0);
        check("rst_wait.rsp_valid", 64'(rsp_valid[0]), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        ncyc_valid = 0;
        rsp_ready[0] = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) ncyc_valid++;
        end
        rsp_ready[0] = 1'b0;
        check("rst_wait.no_response", 64'(ncyc_valid), 64'd0);
        do_op(0, 8'd8, 64'hF0, 64'hFF, 4'd5, 0, "xor_after_reset");
        check("xor_after_reset.value", 64'h0F, alu_math(8'd8, 64'hF0, 64'hFF));

        do_op(1, 8'd4, 64'd1, 64'd63, 4'd1, 0, "l3_sll");
        do_op(1, 8'd5, 64'h8000_0000_0000_0000, 64'd63, 4'd2, 0, "l3_srl");

        for (int i = 0; i < 60; i++) begin
            int d;
            d  = i % 2;
            op = 8'($urandom_range(0, 11));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            do_op(d, op, a, b, 4'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
